// File: rtl/lock_client.sv
// -----------------------------------------------------------------------------
// lock_client
// Accelerator-side initiator of the OmpSs lock protocol. Local lock/unlock
// requests become 64-bit command words on outStream. For a lock, the client
// waits for the 8-bit ack on inStream. It retries after a fixed backoff on
// every reject, and it reports the grant back to the core.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready    local request handshake
//   cmd_unlock         0 = lock, 1 = unlock
//   cmd_lock_id        lock id of the request
//   rsp_valid/rsp_err  one-cycle completion pulse; rsp_err flags an illegal request
//   held               this client currently owns a lock
//   retry_count        rejects seen for the current lock request (saturating)
//   outStream_*        command word stream to the lock responder (TID = ACC_ID)
//   inStream_*         ack stream from the lock responder
// -----------------------------------------------------------------------------
// state       | meaning
// S_IDLE      | ready for a local request
// S_SEND_LOCK | lock word offered on outStream
// S_WAIT_ACK  | waiting for the responder's ack
// S_BACKOFF   | idle delay after a reject before re-issuing the lock
// S_SEND_UNLK | unlock word offered on outStream
// S_RESP      | one-cycle completion pulse to the core
// -----------------------------------------------------------------------------
module lock_client #(
  parameter logic [3:0]  ACC_ID          = 4'd0,
  parameter int unsigned LOCK_ID_BITS    = 8,
  parameter logic [7:0]  CMD_LOCK_CODE   = 8'h04,
  parameter logic [7:0]  CMD_UNLOCK_CODE = 8'h05,
  parameter logic [7:0]  ACK_OK_CODE     = 8'h01,
  parameter int unsigned RETRY_DELAY     = 16,
  parameter int unsigned CNT_BITS        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_unlock,
  input  logic [LOCK_ID_BITS-1:0] cmd_lock_id,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic                    held,
  output logic [CNT_BITS-1:0]     retry_count,
  output logic [63:0]             outStream_TDATA,
  output logic                    outStream_TVALID,
  input  logic                    outStream_TREADY,
  output logic [3:0]              outStream_TID,
  input  logic [7:0]              inStream_TDATA,
  input  logic                    inStream_TVALID,
  output logic                    inStream_TREADY
);

  // The backoff timer is loaded with RETRY_DELAY-1. It counts down to zero, so
  // exactly RETRY_DELAY idle cycles separate a reject from the re-issued lock.
  localparam int unsigned BO_BITS = (RETRY_DELAY > 2) ? $clog2(RETRY_DELAY) : 1;
  localparam logic [BO_BITS-1:0] BO_LOAD =
    BO_BITS'((RETRY_DELAY > 0) ? (RETRY_DELAY - 1) : 0);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SEND_LOCK = 3'd1,
    S_WAIT_ACK  = 3'd2,
    S_BACKOFF   = 3'd3,
    S_SEND_UNLK = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [LOCK_ID_BITS-1:0] id_q, id_d;
  logic                    unlock_q, unlock_d;
  logic [CNT_BITS-1:0]     retry_q, retry_d;
  logic [BO_BITS-1:0]      bo_q, bo_d;
  logic                    held_q, held_d;
  logic                    tvalid_q, tvalid_d;
  logic                    in_ready_q, in_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    unlock_d  = unlock_q;
    retry_d   = retry_q;
    bo_d      = bo_q;
    held_d    = held_q;
    rsp_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          id_d     = cmd_lock_id;
          unlock_d = cmd_unlock;
          retry_d  = '0;
          if (cmd_unlock) begin
            state_d = S_SEND_UNLK;
          end else if (held_q) begin
            // Nested lock is refused locally; the responder never sees it.
            state_d   = S_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = S_SEND_LOCK;
          end
        end
      end
      S_SEND_LOCK: begin
        if (outStream_TREADY) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (inStream_TVALID) begin
          if (inStream_TDATA == ACK_OK_CODE) begin
            held_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            retry_d = (&retry_q) ? retry_q : retry_q + CNT_BITS'(1);
            if (RETRY_DELAY == 0) begin
              state_d = S_SEND_LOCK;
            end else begin
              bo_d    = BO_LOAD;
              state_d = S_BACKOFF;
            end
          end
        end
      end
      S_BACKOFF: begin
        if (bo_q == '0) state_d = S_SEND_LOCK;
        else            bo_d    = bo_q - BO_BITS'(1);
      end
      S_SEND_UNLK: begin
        if (outStream_TREADY) begin
          held_d  = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Stream and response outputs are decoded from the next state, so they
    // come out of flops and line up with the state they belong to.
    tvalid_d    = (state_d == S_SEND_LOCK) || (state_d == S_SEND_UNLK);
    in_ready_d  = (state_d == S_WAIT_ACK);
    rsp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      unlock_q    <= 1'b0;
      retry_q     <= '0;
      bo_q        <= '0;
      held_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      unlock_q    <= unlock_d;
      retry_q     <= retry_d;
      bo_q        <= bo_d;
      held_q      <= held_d;
      tvalid_q    <= tvalid_d;
      in_ready_q  <= in_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Command word: {zeros, lock id, opcode}. It is built from the latched
  // request, so it stays stable for the whole time TVALID is held.
  always_comb begin
    outStream_TDATA                       = '0;
    outStream_TDATA[7:0]                  = unlock_q ? CMD_UNLOCK_CODE : CMD_LOCK_CODE;
    outStream_TDATA[8 +: LOCK_ID_BITS]    = id_q;
  end

  // cmd_ready is gated by rst directly, so no request is taken while reset is held.
  assign cmd_ready        = (state_q == S_IDLE) && !rst;
  assign outStream_TVALID = tvalid_q;
  assign outStream_TID    = ACC_ID;
  assign inStream_TREADY  = in_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_err          = rsp_err_q;
  assign held             = held_q;
  assign retry_count      = retry_q;

endmodule
